// File: rtl/vend_transaction_controller.sv
// Purchase sequencer: collects coins, validates a selection against price/stock,
// drives per-item dispense handshakes and pays change back coin by coin.
module vend_transaction_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CREDIT_W       = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  output logic                coin_ready,
  input  logic                select_valid,
  input  logic [2:0]          select_id,
  input  logic [3:0]          select_qty,
  input  logic                cancel,
  input  logic [7:0]          price,
  input  logic [4:0]          stock,
  output logic [2:0]          buy_id,
  output logic [3:0]          buy_qty,
  output logic                buy_pulse,
  output logic                vend_req,
  input  logic                vend_ack,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          err_code,
  output logic                done,
  output logic [2:0]          state
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned COST_W = 12;
  localparam int unsigned CMP_W  = (CREDIT_W > COST_W) ? CREDIT_W : COST_W;

  // Highest credit that can still absorb a 50-unit coin without wrapping
  localparam logic [CREDIT_W-1:0] COIN_LIMIT = {CREDIT_W{1'b1}} - CREDIT_W'(50);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STOCK = 2'b01;
  localparam logic [1:0] ERR_FUNDS = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_VEND    = 3'd3,
    S_CHANGE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [3:0]          remaining_q, remaining_d;
  logic [2:0]          buy_id_q, buy_id_d;
  logic [3:0]          buy_qty_q, buy_qty_d;
  logic [1:0]          err_q, err_d;
  logic                buy_pulse_q, buy_pulse_d;
  logic                done_q, done_d;

  logic                coin_accept_c;
  logic [1:0]          change_coin_c;
  logic [5:0]          change_units_c;
  logic [CREDIT_W-1:0] change_rem_c;
  logic [COST_W-1:0]   cost_c;

  function automatic logic [5:0] coin_units(input logic [1:0] c);
    case (c)
      2'b00:   coin_units = 6'd5;
      2'b01:   coin_units = 6'd10;
      2'b10:   coin_units = 6'd20;
      default: coin_units = 6'd50;
    endcase
  endfunction

  // Handshake-facing outputs decode straight from registered state
  assign coin_ready    = ((state_q == S_IDLE) || (state_q == S_COLLECT)) && (credit_q <= COIN_LIMIT);
  assign coin_accept_c = coin_valid & coin_ready;
  assign vend_req      = (state_q == S_VEND);
  assign change_valid  = (state_q == S_CHANGE);

  always_comb begin
    if (credit_q >= CREDIT_W'(50))      change_coin_c = 2'b11;
    else if (credit_q >= CREDIT_W'(20)) change_coin_c = 2'b10;
    else if (credit_q >= CREDIT_W'(10)) change_coin_c = 2'b01;
    else                                change_coin_c = 2'b00;
  end

  assign change_units_c = coin_units(change_coin_c);
  assign change_rem_c   = (credit_q > CREDIT_W'(change_units_c)) ?
                          (credit_q - CREDIT_W'(change_units_c)) : '0;
  assign cost_c         = COST_W'(price) * COST_W'(buy_qty_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      tmo_q       <= '0;
      remaining_q <= '0;
      buy_id_q    <= '0;
      buy_qty_q   <= '0;
      err_q       <= ERR_NONE;
      buy_pulse_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      tmo_q       <= tmo_d;
      remaining_q <= remaining_d;
      buy_id_q    <= buy_id_d;
      buy_qty_q   <= buy_qty_d;
      err_q       <= err_d;
      buy_pulse_q <= buy_pulse_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    tmo_d       = tmo_q;
    remaining_d = remaining_q;
    buy_id_d    = buy_id_q;
    buy_qty_d   = buy_qty_q;
    err_d       = err_q;
    buy_pulse_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (coin_accept_c) begin
          credit_d = credit_q + CREDIT_W'(coin_units(coin_value));
          tmo_d    = '0;
          state_d  = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // A coin landing alongside select/cancel is counted first
        if (coin_accept_c) credit_d = credit_q + CREDIT_W'(coin_units(coin_value));
        if (cancel) begin
          tmo_d = '0;
          if (credit_d != '0) begin
            state_d = S_CHANGE;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else if (select_valid) begin
          tmo_d     = '0;
          buy_id_d  = select_id;
          buy_qty_d = select_qty;
          err_d     = ERR_NONE;
          state_d   = S_CHECK;
        end else if (coin_accept_c) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = '0;
          state_d = S_CHANGE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_CHECK: begin
        if ((buy_qty_q == 4'd0) || (stock < {1'b0, buy_qty_q})) begin
          err_d   = ERR_STOCK;
          state_d = S_COLLECT;
        end else if (CMP_W'(credit_q) < CMP_W'(cost_c)) begin
          err_d   = ERR_FUNDS;
          state_d = S_COLLECT;
        end else begin
          credit_d    = credit_q - CREDIT_W'(cost_c);
          buy_pulse_d = 1'b1;
          remaining_d = buy_qty_q;
          state_d     = S_VEND;
        end
      end

      S_VEND: begin
        if (vend_ack) begin
          if (remaining_q <= 4'd1) begin
            remaining_d = '0;
            if (credit_q != '0) begin
              state_d = S_CHANGE;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            remaining_d = remaining_q - 4'd1;
          end
        end
      end

      S_CHANGE: begin
        // Residue smaller than the smallest coin is forfeited
        if (change_ready) begin
          if (change_rem_c < CREDIT_W'(5)) begin
            credit_d = '0;
            state_d  = S_IDLE;
            done_d   = 1'b1;
          end else begin
            credit_d = change_rem_c;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign state       = state_q;
  assign credit      = credit_q;
  assign buy_id      = buy_id_q;
  assign buy_qty     = buy_qty_q;
  assign buy_pulse   = buy_pulse_q;
  assign err_code    = err_q;
  assign done        = done_q;
  assign change_coin = change_coin_c;

endmodule

// File: tb/tb_vend_transaction_controller.sv
// Scoreboard bench for vend_transaction_controller: stimulus queues expected
// events/status, a negedge monitor compares them against the DUT.
module tb_vend_transaction_controller;

  localparam int unsigned CW = 16;

  localparam int EV_BUY  = 0;
  localparam int EV_CHG  = 1;
  localparam int EV_DONE = 2;

  localparam int SEL_STATE  = 0;
  localparam int SEL_CREDIT = 1;
  localparam int SEL_ERR    = 2;
  localparam int SEL_CREADY = 3;
  localparam int SEL_CCOIN  = 4;
  localparam int SEL_VREQ   = 5;
  localparam int SEL_CVALID = 6;
  localparam int SEL_BUYID  = 7;
  localparam int SEL_BUYQTY = 8;
  localparam int SEL_DRAIN  = 9;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } st_t;

  logic          CLK;
  logic          RESET;
  logic          coin_valid;
  logic [1:0]    coin_value;
  logic          coin_ready;
  logic          select_valid;
  logic [2:0]    select_id;
  logic [3:0]    select_qty;
  logic          cancel;
  logic [7:0]    price;
  logic [4:0]    stock;
  logic [2:0]    buy_id;
  logic [3:0]    buy_qty;
  logic          buy_pulse;
  logic          vend_req;
  logic          vend_ack;
  logic          change_valid;
  logic [1:0]    change_coin;
  logic          change_ready;
  logic [CW-1:0] credit;
  logic [1:0]    err_code;
  logic          done;
  logic [2:0]    state;

  ev_t evq[$];
  st_t stq[$];
  int  n_vec  = 0;
  int  n_fail = 0;

  vend_transaction_controller #(.TIMEOUT_CYCLES(16), .CREDIT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(coin_ready),
    .select_valid(select_valid), .select_id(select_id), .select_qty(select_qty),
    .cancel(cancel), .price(price), .stock(stock),
    .buy_id(buy_id), .buy_qty(buy_qty), .buy_pulse(buy_pulse),
    .vend_req(vend_req), .vend_ack(vend_ack),
    .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
    .credit(credit), .err_code(err_code), .done(done), .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: output events against the event queue, then pending status probes
  always @(negedge CLK) begin
    ev_t e;
    st_t s;
    int  act;
    if (buy_pulse) begin
      if (evq.size() == 0 || evq[0].kind != EV_BUY) chk("unexpected_buy_pulse", 1, 0);
      else begin
        e = evq.pop_front();
        chk("buy_id", int'(buy_id), e.a);
        chk("buy_qty", int'(buy_qty), e.b);
        chk("buy_credit", int'(credit), e.c);
      end
    end
    if (change_valid && change_ready) begin
      if (evq.size() == 0 || evq[0].kind != EV_CHG) chk("unexpected_change", 1, 0);
      else begin
        e = evq.pop_front();
        chk("change_coin", int'(change_coin), e.a);
        chk("change_credit", int'(credit), e.b);
      end
    end
    if (done) begin
      if (evq.size() == 0 || evq[0].kind != EV_DONE) chk("unexpected_done", 1, 0);
      else begin
        e = evq.pop_front();
        chk("done_credit", int'(credit), e.a);
        chk("done_state", int'(state), 0);
      end
    end
    while (stq.size() > 0) begin
      s = stq.pop_front();
      case (s.sel)
        SEL_STATE:  act = int'(state);
        SEL_CREDIT: act = int'(credit);
        SEL_ERR:    act = int'(err_code);
        SEL_CREADY: act = int'(coin_ready);
        SEL_CCOIN:  act = int'(change_coin);
        SEL_VREQ:   act = int'(vend_req);
        SEL_CVALID: act = int'(change_valid);
        SEL_BUYID:  act = int'(buy_id);
        SEL_BUYQTY: act = int'(buy_qty);
        default:    act = evq.size();
      endcase
      chk(s.name, act, s.exp);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic want(input string name, input int sel, input int exp);
    st_t s;
    s.name = name;
    s.sel  = sel;
    s.exp  = exp;
    stq.push_back(s);
  endtask

  task automatic push_ev(input int kind, input int a, input int b, input int c);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    e.c    = c;
    evq.push_back(e);
  endtask

  task automatic coin(input logic [1:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic sel(input logic [2:0] id, input logic [3:0] qty);
    select_valid = 1'b1;
    select_id    = id;
    select_qty   = qty;
    tick();
    select_valid = 1'b0;
  endtask

  task automatic acks(input int n);
    vend_ack = 1'b1;
    repeat (n) tick();
    vend_ack = 1'b0;
  endtask

  task automatic takes(input int n);
    change_ready = 1'b1;
    repeat (n) tick();
    change_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    coin_valid = 1'b0; coin_value = 2'b00;
    select_valid = 1'b0; select_id = 3'd0; select_qty = 4'd0;
    cancel = 1'b0; price = 8'd0; stock = 5'd0;
    vend_ack = 1'b0; change_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    want("rst_state", SEL_STATE, 0);
    want("rst_credit", SEL_CREDIT, 0);
    want("rst_err", SEL_ERR, 0);
    want("rst_coin_ready", SEL_CREADY, 1);
    want("rst_vend_req", SEL_VREQ, 0);
    want("rst_change_valid", SEL_CVALID, 0);
    want("rst_buy_id", SEL_BUYID, 0);
    want("rst_buy_qty", SEL_BUYQTY, 0);
    tick();

    // 1: 90 credit, buy 2 x 15, change 50 + 10
    price = 8'd15; stock = 5'd10;
    coin(2'b00); coin(2'b00); coin(2'b01); coin(2'b10); coin(2'b11);
    want("t1_credit", SEL_CREDIT, 90);
    want("t1_collect", SEL_STATE, 1);
    push_ev(EV_BUY, 1, 2, 60);
    sel(3'd1, 4'd2);
    tick();
    want("t1_vend", SEL_STATE, 3);
    want("t1_vend_req", SEL_VREQ, 1);
    acks(2);
    want("t1_change", SEL_STATE, 4);
    want("t1_vend_req_drop", SEL_VREQ, 0);
    want("t1_coin50", SEL_CCOIN, 3);
    push_ev(EV_CHG, 3, 60, 0);
    push_ev(EV_CHG, 1, 10, 0);
    push_ev(EV_DONE, 0, 0, 0);
    takes(2);
    want("t1_idle", SEL_STATE, 0);

    // 2: insufficient funds, then top up and buy
    price = 8'd25;
    coin(2'b01);
    sel(3'd2, 4'd1);
    tick();
    want("t2_err_funds", SEL_ERR, 2);
    want("t2_collect", SEL_STATE, 1);
    want("t2_credit", SEL_CREDIT, 10);
    coin(2'b10);
    push_ev(EV_BUY, 2, 1, 5);
    sel(3'd2, 4'd1);
    tick();
    want("t2_err_clear", SEL_ERR, 0);
    acks(1);
    want("t2_change", SEL_STATE, 4);
    want("t2_coin5", SEL_CCOIN, 0);
    push_ev(EV_CHG, 0, 5, 0);
    push_ev(EV_DONE, 0, 0, 0);
    takes(1);
    want("t2_idle", SEL_STATE, 0);

    // 3: stock shortfall, zero quantity, then qty == stock succeeds
    price = 8'd1; stock = 5'd3;
    coin(2'b11);
    sel(3'd4, 4'd4);
    tick();
    want("t3_err_stock", SEL_ERR, 1);
    want("t3_collect", SEL_STATE, 1);
    want("t3_credit", SEL_CREDIT, 50);
    sel(3'd4, 4'd0);
    tick();
    want("t3_err_qty0", SEL_ERR, 1);
    want("t3_collect2", SEL_STATE, 1);
    price = 8'd10;
    push_ev(EV_BUY, 4, 3, 20);
    sel(3'd4, 4'd3);
    tick();
    acks(3);
    want("t3_change", SEL_STATE, 4);
    want("t3_coin20", SEL_CCOIN, 2);
    push_ev(EV_CHG, 2, 20, 0);
    push_ev(EV_DONE, 0, 0, 0);
    takes(1);

    // 4: timeout after 16 idle COLLECT cycles, change held stable
    coin(2'b10);
    repeat (15) tick();
    want("t4_pre_timeout", SEL_STATE, 1);
    tick();
    want("t4_timeout", SEL_STATE, 4);
    want("t4_credit", SEL_CREDIT, 20);
    for (int i = 0; i < 3; i++) begin
      want("t4_coin_stable", SEL_CCOIN, 2);
      want("t4_valid_held", SEL_CVALID, 1);
      tick();
    end
    push_ev(EV_CHG, 2, 20, 0);
    push_ev(EV_DONE, 0, 0, 0);
    takes(1);
    want("t4_idle", SEL_STATE, 0);
    want("t4_credit0", SEL_CREDIT, 0);

    // 5: coin+select+cancel together, then coins refused during VEND
    coin(2'b01);
    coin_valid = 1'b1; coin_value = 2'b10;
    select_valid = 1'b1; select_id = 3'd7; select_qty = 4'd1;
    cancel = 1'b1;
    tick();
    coin_valid = 1'b0; select_valid = 1'b0; cancel = 1'b0;
    want("t5_cancel_wins", SEL_STATE, 4);
    want("t5_refund", SEL_CREDIT, 30);
    want("t5_buy_id_kept", SEL_BUYID, 4);
    push_ev(EV_CHG, 2, 30, 0);
    push_ev(EV_CHG, 1, 10, 0);
    push_ev(EV_DONE, 0, 0, 0);
    takes(2);
    price = 8'd10; stock = 5'd5;
    coin(2'b11);
    push_ev(EV_BUY, 1, 5, 0);
    sel(3'd1, 4'd5);
    tick();
    coin_valid = 1'b1; coin_value = 2'b11;
    for (int i = 0; i < 2; i++) begin
      want("t5_vend_coin_ready", SEL_CREADY, 0);
      want("t5_vend_credit", SEL_CREDIT, 0);
      tick();
    end
    coin_valid = 1'b0;
    push_ev(EV_DONE, 0, 0, 0);
    acks(5);
    want("t5_idle", SEL_STATE, 0);

    // 6: reset mid-VEND with two items outstanding
    coin(2'b11);
    push_ev(EV_BUY, 0, 2, 30);
    sel(3'd0, 4'd2);
    tick();
    tick();
    #2 RESET = 1'b1;
    want("t6_state", SEL_STATE, 0);
    want("t6_credit", SEL_CREDIT, 0);
    want("t6_vend_req", SEL_VREQ, 0);
    want("t6_buy_qty", SEL_BUYQTY, 0);
    tick();
    tick();
    RESET = 1'b0;
    acks(1);
    want("t6_ack_ignored_state", SEL_STATE, 0);
    want("t6_ack_ignored_credit", SEL_CREDIT, 0);
    want("t6_ack_ignored_vreq", SEL_VREQ, 0);
    want("drain_events", SEL_DRAIN, 0);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
